// File: rtl/bram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter_if
//
// Bundles every non-clock signal of the BRAM port-A arbiter.
//
//   Requester side (one lane per requester, flattened vectors):
//     req_valid  - command valid, one bit per requester
//     req_ready  - grant/accept, one-hot or zero
//     req_we     - 1 = write, 0 = read
//     req_addr   - requester i at [i*ADDR_W +: ADDR_W]
//     req_wdata  - requester i at [i*DATA_W +: DATA_W]
//     rsp_valid  - one-hot read-response strobe, no backpressure
//     rsp_data   - read data, qualified by any rsp_valid bit
//
//   RAM side (port A of the block RAM):
//     ram_we / ram_addr / ram_din - registered command towards the RAM
//     ram_dout                    - read data returning from the RAM
//
//   Status:
//     inflight   - reads issued but not yet returned
//
// Modports:
//   master - the outside world (clients plus RAM) driving the arbiter
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface bram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 36,
    parameter int ADDR_W  = 9
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_din;
    logic [DATA_W-1:0]         ram_dout;

    logic [2:0]                inflight;

    // Clients and the RAM model sit on this side.
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output ram_dout,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        input  inflight
    );

    // The arbiter sits on this side.
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  ram_dout,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output ram_we,
        output ram_addr,
        output ram_din,
        output inflight
    );

endinterface

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Round-robin arbiter sharing port A of the dual-port block RAM among
// NUM_REQ requesters. Each requester issues single-beat read or write
// commands over valid/ready. The winning command is registered onto the
// RAM port; read data is routed back to the originating requester after
// the fixed RAM read latency using a small tag pipeline.
//
// Ports:
//   clka - clock for the arbiter and RAM port A
//   rstb - synchronous, active-high reset
//   bus  - bram_port_arbiter_if.slave (requester, response, RAM, status)
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//   DATA_W     - RAM data width
//   ADDR_W     - RAM address width
//   RD_LATENCY - RAM edges from command sample to valid dout (1 or 2)
//
// Timing: a read accepted in cycle N (handshake at the edge closing N)
// has its response strobed during cycle N+RD_LATENCY+1.
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 36,
    parameter int ADDR_W     = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                clka,
    input  logic                rstb,
    bram_port_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = RD_LATENCY + 1;

    // Round-robin pointer: the requester searched first next cycle.
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;

    // Combinational arbitration result.
    logic               grantValid;
    logic [PTR_W-1:0]   grantIdx;
    logic [PTR_W-1:0]   candIdx;
    logic               handshake;
    logic [NUM_REQ-1:0] readyVec;

    // Command fields of the granted requester.
    logic               selWe;
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selWdata;

    // Registered RAM command.
    logic               ramWe_q;
    logic               ramWe_d;
    logic [ADDR_W-1:0]  ramAddr_q;
    logic [ADDR_W-1:0]  ramAddr_d;
    logic [DATA_W-1:0]  ramDin_q;
    logic [DATA_W-1:0]  ramDin_d;

    // Tag pipeline: stage 0 is loaded on the handshake edge, the last
    // stage lines up with valid data on ram_dout.
    logic [DEPTH-1:0]   tagValid_q;
    logic [DEPTH-1:0]   tagValid_d;
    logic [PTR_W-1:0]   tagId_q [DEPTH];
    logic [PTR_W-1:0]   tagId_d [DEPTH];

    // Response strobe and outstanding-read counter.
    logic               readAccept;
    logic               rspFire;
    logic [NUM_REQ-1:0] rspVec;
    logic [2:0]         inflight_q;
    logic [2:0]         inflight_d;

    // Search requesters starting at ptr and wrapping around; the first
    // one holding req_valid wins. Only the first hit is kept, so later
    // candidates in the loop cannot override an earlier grant.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candIdx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grantValid && bus.req_valid[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // Ready is withheld for the whole time reset is asserted, so no
    // command can slip into the RAM while the pipeline is being cleared.
    always_comb begin
        readyVec  = '0;
        handshake = grantValid && !rstb;
        if (handshake) begin
            readyVec[grantIdx] = 1'b1;
        end
    end

    // Pick out the winner's command fields from the flattened buses.
    always_comb begin
        selWe    = bus.req_we[grantIdx];
        selAddr  = bus.req_addr[int'(grantIdx) * ADDR_W +: ADDR_W];
        selWdata = bus.req_wdata[int'(grantIdx) * DATA_W +: DATA_W];
    end

    // Next pointer moves just past the winner so it goes to the back of
    // the queue; without a handshake the pointer stays put.
    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            if (int'(grantIdx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grantIdx + 1'b1;
            end
        end
    end

    // RAM command next-state. Write enable is a single-cycle pulse per
    // accepted write; address and data hold when idle so the RAM port
    // does not toggle needlessly.
    always_comb begin
        ramWe_d   = 1'b0;
        ramAddr_d = ramAddr_q;
        ramDin_d  = ramDin_q;
        if (handshake) begin
            ramWe_d   = selWe;
            ramAddr_d = selAddr;
            ramDin_d  = selWdata;
        end
    end

    // Tag pipeline shift. Only reads load a valid tag, which is why
    // writes never produce a response. Responses leave in the same order
    // commands entered, giving in-order completion for free.
    always_comb begin
        readAccept    = handshake && !selWe;
        tagValid_d[0] = readAccept;
        tagId_d[0]    = grantIdx;
        for (int s = 1; s < DEPTH; s++) begin
            tagValid_d[s] = tagValid_q[s-1];
            tagId_d[s]    = tagId_q[s-1];
        end
    end

    // Response strobe decoded from the oldest tag stage.
    always_comb begin
        rspFire = tagValid_q[DEPTH-1];
        rspVec  = '0;
        if (rspFire) begin
            rspVec[tagId_q[DEPTH-1]] = 1'b1;
        end
    end

    // Outstanding reads: an accept and a delivery in the same cycle
    // cancel out. The tag pipeline bounds the count at DEPTH.
    always_comb begin
        inflight_d = inflight_q;
        if (readAccept && !rspFire) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!readAccept && rspFire) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    // All state in one synchronous-reset register block. Clearing the tag
    // pipeline discards reads that were in flight at reset, so their data
    // is never strobed back to a requester.
    always_ff @(posedge clka) begin
        if (rstb) begin
            ptr_q      <= '0;
            ramWe_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramDin_q   <= '0;
            tagValid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tagId_q[s] <= '0;
            end
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            ramWe_q    <= ramWe_d;
            ramAddr_q  <= ramAddr_d;
            ramDin_q   <= ramDin_d;
            tagValid_q <= tagValid_d;
            for (int s = 0; s < DEPTH; s++) begin
                tagId_q[s] <= tagId_d[s];
            end
            inflight_q <= inflight_d;
        end
    end

    // Drive the interface outputs. Read data passes straight through;
    // consumers qualify it with rsp_valid.
    assign bus.req_ready = readyVec;
    assign bus.rsp_valid = rspVec;
    assign bus.rsp_data  = bus.ram_dout;
    assign bus.ram_we    = ramWe_q;
    assign bus.ram_addr  = ramAddr_q;
    assign bus.ram_din   = ramDin_q;
    assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed testbench for bram_port_arbiter. Two instances share clka and
// rstb: "dut" in output-register mode (RD_LATENCY=2) and "dutLow" in
// low-latency mode (RD_LATENCY=1). A behavioural RAM model for each sits
// on the RAM side; both read the same preset contents.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 36;
    localparam int ADDR_W  = 9;

    logic clka = 1'b0;
    logic rstb;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clka = ~clka;

    bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) busLow ();

    bram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(2)
    ) dut (
        .clka(clka),
        .rstb(rstb),
        .bus (bus)
    );

    bram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(1)
    ) dutLow (
        .clka(clka),
        .rstb(rstb),
        .bus (busLow)
    );

    // RAM contents: preset values unless a write has landed at that address.
    bit   [511:0]        written;
    logic [DATA_W-1:0]   wmem [512];
    logic [DATA_W-1:0]   pipeHi;
    logic [DATA_W-1:0]   doutHi;
    logic [DATA_W-1:0]   doutLow;

    function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        case (a)
            9'h005:  v = 36'h1_2345_6789;
            9'h007:  v = 36'h7_7777_7777;
            9'h010:  v = 36'h0_0000_0A00;
            9'h011:  v = 36'h0_0000_0A01;
            9'h012:  v = 36'h0_0000_0A02;
            9'h013:  v = 36'h0_0000_0A03;
            default: v = {27'b0, a};
        endcase
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] memRead(input logic [ADDR_W-1:0] a);
        return written[a] ? wmem[a] : initVal(a);
    endfunction

    // Port-A RAM models: two-stage read for output-register mode, one
    // stage for low-latency mode. Only the main instance issues writes.
    always @(posedge clka) begin
        if (bus.ram_we) begin
            wmem[bus.ram_addr]    <= bus.ram_din;
            written[bus.ram_addr] <= 1'b1;
        end
        pipeHi  <= memRead(bus.ram_addr);
        doutHi  <= pipeHi;
        doutLow <= memRead(busLow.ram_addr);
    end

    assign bus.ram_dout    = doutHi;
    assign busLow.ram_dout = doutLow;

    // Step to just after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge clka);
        #1;
    endtask

    // Drive one requester lane of the main instance.
    task automatic applyStimulus(input logic [1:0] idx, input logic v, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        bus.req_valid[idx]                   = v;
        bus.req_we[idx]                      = we;
        bus.req_addr[idx*ADDR_W +: ADDR_W]   = addr;
        bus.req_wdata[idx*DATA_W +: DATA_W]  = wd;
    endtask

    task automatic clearAll();
        bus.req_valid = '0;
        bus.req_we    = '0;
    endtask

    // Reset holds ready low even with every requester asking, and clears
    // the RAM command registers and the status outputs.
    task automatic test_reset();
        rstb = 1'b1;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        busLow.req_valid = '0;
        busLow.req_we    = '0;
        busLow.req_addr  = '0;
        busLow.req_wdata = '0;
        clearAll();
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(2'(i), 1'b1, 1'b0, 9'(i), '0);
        repeat (3) begin
            @(negedge clka);
            testsRun++;
            if (bus.req_ready !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready);
            end
        end
        testsRun++;
        if ({bus.rsp_valid, bus.inflight, bus.ram_we} !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: rsp_valid=%b inflight=%0d ram_we=%b expected all 0",
                     bus.rsp_valid, bus.inflight, bus.ram_we);
        end
        testsRun++;
        if (bus.ram_addr !== 9'h000 || bus.ram_din !== 36'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_cmd: ram_addr=%h ram_din=%h expected 0/0", bus.ram_addr, bus.ram_din);
        end
        clearAll();
        nextCycle();
        rstb = 1'b0;
        nextCycle();
    endtask

    // All four requesters read continuously from ptr=0: grants rotate
    // 0,1,2,3,... and responses follow three cycles later with no gaps.
    task automatic test_round_robin();
        logic [3:0] expReady;
        logic [3:0] expRsp;
        int         expInflight;
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(2'(i), 1'b1, 1'b0, 9'(16 + i), '0);
        for (int c = 0; c < 12; c++) begin
            if (c == 8) clearAll();
            expReady    = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            expRsp      = (c >= 3 && c <= 10) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000;
            expInflight = (c == 0) ? 0 : (c <= 2) ? c : (c <= 8) ? 3 : 11 - c;
            @(negedge clka);
            testsRun++;
            if (bus.req_ready !== expReady) begin
                testsFailed++;
                $display("[TB] FAIL rr_ready c=%0d: got %b expected %b", c, bus.req_ready, expReady);
            end
            testsRun++;
            if (bus.rsp_valid !== expRsp) begin
                testsFailed++;
                $display("[TB] FAIL rr_rsp c=%0d: got %b expected %b", c, bus.rsp_valid, expRsp);
            end
            if (expRsp != 4'b0000) begin
                testsRun++;
                if (bus.rsp_data !== 36'hA00 + 36'((c - 3) % 4)) begin
                    testsFailed++;
                    $display("[TB] FAIL rr_data c=%0d: got %h expected %h", c, bus.rsp_data,
                             36'hA00 + 36'((c - 3) % 4));
                end
            end
            testsRun++;
            if (bus.inflight !== 3'(expInflight)) begin
                testsFailed++;
                $display("[TB] FAIL rr_inflight c=%0d: got %0d expected %0d", c, bus.inflight, expInflight);
            end
            nextCycle();
        end
    endtask

    // Lone read from requester 2: response three cycles after the grant,
    // inflight 1 until the response cycle has passed.
    task automatic test_single_read();
        applyStimulus(2'd2, 1'b1, 1'b0, 9'h005, '0);
        @(negedge clka);
        testsRun++;
        if (bus.req_ready !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL single_grant: got %b expected 0100", bus.req_ready);
        end
        nextCycle();
        clearAll();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clka);
            testsRun++;
            if (bus.inflight !== ((k <= 3) ? 3'd1 : 3'd0)) begin
                testsFailed++;
                $display("[TB] FAIL single_inflight k=%0d: got %0d expected %0d", k, bus.inflight,
                         (k <= 3) ? 1 : 0);
            end
            testsRun++;
            if (bus.rsp_valid !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
                testsFailed++;
                $display("[TB] FAIL single_rsp k=%0d: got %b", k, bus.rsp_valid);
            end
            if (k == 3) begin
                testsRun++;
                if (bus.rsp_data !== 36'h1_2345_6789) begin
                    testsFailed++;
                    $display("[TB] FAIL single_data: got %h expected 123456789", bus.rsp_data);
                end
            end
            nextCycle();
        end
    endtask

    // Write from req0 then read of the same address from req1 on the next
    // cycle: ram_we pulses once and the read returns the new data.
    task automatic test_write_read();
        applyStimulus(2'd0, 1'b1, 1'b1, 9'h1FF, 36'h0AA);
        @(negedge clka);
        testsRun++;
        if (bus.req_ready !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL wr_grant: got %b expected 0001", bus.req_ready);
        end
        nextCycle();
        clearAll();
        applyStimulus(2'd1, 1'b1, 1'b0, 9'h1FF, '0);
        @(negedge clka);
        testsRun++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 9'h1FF || bus.ram_din !== 36'h0AA) begin
            testsFailed++;
            $display("[TB] FAIL wr_cmd: we=%b addr=%h din=%h expected 1/1ff/0aa",
                     bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        testsRun++;
        if (bus.req_ready !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL rd_grant: got %b expected 0010", bus.req_ready);
        end
        nextCycle();
        clearAll();
        for (int k = 2; k <= 4; k++) begin
            @(negedge clka);
            testsRun++;
            if (bus.ram_we !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL wr_pulse k=%0d: ram_we got %b expected 0", k, bus.ram_we);
            end
            testsRun++;
            if (bus.rsp_valid !== ((k == 4) ? 4'b0010 : 4'b0000)) begin
                testsFailed++;
                $display("[TB] FAIL wr_rsp k=%0d: got %b", k, bus.rsp_valid);
            end
            if (k == 4) begin
                testsRun++;
                if (bus.rsp_data !== 36'h0AA) begin
                    testsFailed++;
                    $display("[TB] FAIL raw_data: got %h expected 0aa", bus.rsp_data);
                end
            end
            nextCycle();
        end
    endtask

    // ptr is 2 here. With req0 and req3 valid, req3 wins then req0; with
    // ptr now 1, req1 beats a still-valid req0. Responses follow in order.
    task automatic test_sparse();
        logic [3:0]        expReady;
        logic [3:0]        expRsp;
        logic [DATA_W-1:0] expData;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin
                    applyStimulus(2'd0, 1'b1, 1'b0, 9'h020, '0);
                    applyStimulus(2'd3, 1'b1, 1'b0, 9'h023, '0);
                end
                1: applyStimulus(2'd3, 1'b0, 1'b0, 9'h023, '0);
                2: applyStimulus(2'd1, 1'b1, 1'b0, 9'h021, '0);
                3: clearAll();
                default: ;
            endcase
            expReady = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0001 : (k == 2) ? 4'b0010 : 4'b0000;
            expRsp   = (k == 3) ? 4'b1000 : (k == 4) ? 4'b0001 : (k == 5) ? 4'b0010 : 4'b0000;
            expData  = (k == 3) ? 36'h023 : (k == 4) ? 36'h020 : 36'h021;
            @(negedge clka);
            testsRun++;
            if (bus.req_ready !== expReady) begin
                testsFailed++;
                $display("[TB] FAIL sparse_ready k=%0d: got %b expected %b", k, bus.req_ready, expReady);
            end
            testsRun++;
            if (bus.rsp_valid !== expRsp) begin
                testsFailed++;
                $display("[TB] FAIL sparse_rsp k=%0d: got %b expected %b", k, bus.rsp_valid, expRsp);
            end
            if (expRsp != 4'b0000) begin
                testsRun++;
                if (bus.rsp_data !== expData) begin
                    testsFailed++;
                    $display("[TB] FAIL sparse_data k=%0d: got %h expected %h", k, bus.rsp_data, expData);
                end
            end
            nextCycle();
        end
    endtask

    // Two reads in flight when reset hits: neither may ever respond, and
    // the counter and pointer restart from zero.
    task automatic test_reset_midflight();
        applyStimulus(2'd0, 1'b1, 1'b0, 9'h010, '0);
        nextCycle();
        clearAll();
        applyStimulus(2'd1, 1'b1, 1'b0, 9'h011, '0);
        nextCycle();
        rstb = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(2'(i), 1'b1, 1'b0, 9'h012, '0);
        @(negedge clka);
        testsRun++;
        if (bus.req_ready !== 4'b0000 || bus.inflight !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL midrst_hold: ready=%b inflight=%0d expected 0000/2", bus.req_ready, bus.inflight);
        end
        nextCycle();
        rstb = 1'b0;
        clearAll();
        for (int k = 3; k <= 6; k++) begin
            @(negedge clka);
            testsRun++;
            if (bus.rsp_valid !== 4'b0000 || bus.inflight !== 3'd0) begin
                testsFailed++;
                $display("[TB] FAIL midrst_drop k=%0d: rsp=%b inflight=%0d expected 0000/0",
                         k, bus.rsp_valid, bus.inflight);
            end
            nextCycle();
        end
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(2'(i), 1'b1, 1'b0, 9'h013, '0);
        @(negedge clka);
        testsRun++;
        if (bus.req_ready !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL midrst_ptr: got %b expected 0001", bus.req_ready);
        end
        nextCycle();
        clearAll();
        repeat (4) nextCycle();
    endtask

    // Low-latency instance: response two cycles after the grant.
    task automatic test_low_latency();
        busLow.req_valid[0]     = 1'b1;
        busLow.req_we[0]        = 1'b0;
        busLow.req_addr[8:0]    = 9'h007;
        @(negedge clka);
        testsRun++;
        if (busLow.req_ready !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL low_grant: got %b expected 0001", busLow.req_ready);
        end
        nextCycle();
        busLow.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clka);
            testsRun++;
            if (busLow.rsp_valid !== ((k == 2) ? 4'b0001 : 4'b0000)) begin
                testsFailed++;
                $display("[TB] FAIL low_rsp k=%0d: got %b", k, busLow.rsp_valid);
            end
            testsRun++;
            if (busLow.inflight !== ((k <= 2) ? 3'd1 : 3'd0)) begin
                testsFailed++;
                $display("[TB] FAIL low_inflight k=%0d: got %0d", k, busLow.inflight);
            end
            if (k == 2) begin
                testsRun++;
                if (busLow.rsp_data !== 36'h7_7777_7777) begin
                    testsFailed++;
                    $display("[TB] FAIL low_data: got %h expected 777777777", busLow.rsp_data);
                end
            end
            nextCycle();
        end
    endtask

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_read();
        test_sparse();
        test_reset_midflight();
        test_low_latency();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
